// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment scan driver: a-g segment patterns
// (bit0=a .. bit6=g, active-high) and a width helper for counters.
package seg7_pkg;

   localparam logic [6:0] SEG_0     = 7'h3F;
   localparam logic [6:0] SEG_1     = 7'h06;
   localparam logic [6:0] SEG_2     = 7'h5B;
   localparam logic [6:0] SEG_3     = 7'h4F;
   localparam logic [6:0] SEG_4     = 7'h66;
   localparam logic [6:0] SEG_5     = 7'h6D;
   localparam logic [6:0] SEG_6     = 7'h7D;
   localparam logic [6:0] SEG_7     = 7'h07;
   localparam logic [6:0] SEG_8     = 7'h7F;
   localparam logic [6:0] SEG_9     = 7'h6F;
   localparam logic [6:0] SEG_A     = 7'h77;
   localparam logic [6:0] SEG_B     = 7'h7C;
   localparam logic [6:0] SEG_C     = 7'h39;
   localparam logic [6:0] SEG_D     = 7'h5E;
   localparam logic [6:0] SEG_E     = 7'h79;
   localparam logic [6:0] SEG_F     = 7'h71;
   localparam logic [6:0] SEG_BLANK = 7'h00;

   // Bits needed to count 0..value-1, never less than 1.
   function automatic int clog2(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) r++;
      return (r < 1) ? 1 : r;
   endfunction

endpackage

// File: rtl/seg7_scan_driver_if.sv
// Valid/ready load channel carrying a packed digit word and decimal points
// from the counter side (master) into the scan driver (slave).
interface seg7_scan_driver_if #(
   parameter int NUM_DIGITS = 4
) ();

   logic                      load;
   logic                      load_rdy;
   logic [4*NUM_DIGITS-1:0]   digits_in;
   logic [NUM_DIGITS-1:0]     dp_in;

   modport master (output load, output digits_in, output dp_in, input load_rdy);
   modport slave  (input load, input digits_in, input dp_in, output load_rdy);

endinterface

// File: rtl/seg7_hex_decoder.sv
// Combinational nibble to seven-segment decoder, hex glyphs A,b,C,d,E,F above 9.
module seg7_hex_decoder
   import seg7_pkg::*;
(
   input  logic [3:0] nibble,
   output logic [6:0] seg
);

   always_comb begin
      seg = SEG_BLANK;
      case (nibble)
         4'h0: seg = SEG_0;
         4'h1: seg = SEG_1;
         4'h2: seg = SEG_2;
         4'h3: seg = SEG_3;
         4'h4: seg = SEG_4;
         4'h5: seg = SEG_5;
         4'h6: seg = SEG_6;
         4'h7: seg = SEG_7;
         4'h8: seg = SEG_8;
         4'h9: seg = SEG_9;
         4'hA: seg = SEG_A;
         4'hB: seg = SEG_B;
         4'hC: seg = SEG_C;
         4'hD: seg = SEG_D;
         4'hE: seg = SEG_E;
         default: seg = SEG_F;
      endcase
   end

endmodule

// File: rtl/seg7_scan_driver.sv
// Multiplexed seven-segment scan driver: double-buffered word swapped only on
// frame boundaries, leading-zero blanking and per-slot PWM brightness.
module seg7_scan_driver
   import seg7_pkg::*;
#(
   parameter int NUM_DIGITS = 4,
   parameter int SCAN_DIV   = 1024,
   parameter int BRIGHT_W   = 3
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  ena,
   seg7_scan_driver_if.slave     ld,
   input  logic                  blank_lz,
   input  logic [BRIGHT_W-1:0]   bright,
   output logic [6:0]            seg_out,
   output logic                  dp_out,
   output logic [NUM_DIGITS-1:0] dig_sel,
   output logic                  frame_start
);

   localparam int PRE_W     = clog2(SCAN_DIV);
   localparam int IDX_W     = clog2(NUM_DIGITS);
   localparam int PHASE_DIV = SCAN_DIV >> BRIGHT_W;
   localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(SCAN_DIV - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

   logic [PRE_W-1:0]        pre_q, pre_d;
   logic [IDX_W-1:0]        idx_q, idx_d;
   logic                    pend_valid_q, pend_valid_d;
   logic [4*NUM_DIGITS-1:0] pend_digits_q, pend_digits_d;
   logic [NUM_DIGITS-1:0]   pend_dp_q, pend_dp_d;
   logic [4*NUM_DIGITS-1:0] shadow_digits_q, shadow_digits_d;
   logic [NUM_DIGITS-1:0]   shadow_dp_q, shadow_dp_d;
   logic [6:0]              seg_q, seg_d;
   logic                    dp_q, dp_d;
   logic [NUM_DIGITS-1:0]   dig_sel_q, dig_sel_d;
   logic                    frame_start_q, frame_start_d;

   logic                    slot_end;
   logic                    frame_wrap;
   logic                    accept;
   logic [3:0]              cur_nib;
   logic [6:0]              dec_seg;
   logic [NUM_DIGITS-1:0]   zero_from;
   logic                    run_zero;
   logic                    lz_blank;
   logic [PRE_W-1:0]        phase;
   logic                    lit;

   assign ld.load_rdy = !pend_valid_q;
   assign accept      = ld.load && !pend_valid_q;
   assign slot_end    = ena && (pre_q == PRE_LAST);
   assign frame_wrap  = slot_end && (idx_q == IDX_LAST);
   assign cur_nib     = shadow_digits_q[4*int'(idx_q) +: 4];

   seg7_hex_decoder u_dec (
      .nibble (cur_nib),
      .seg    (dec_seg)
   );

   always_comb begin
      pre_d = pre_q;
      idx_d = idx_q;
      if (ena) begin
         if (slot_end) begin
            pre_d = '0;
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
         end else begin
            pre_d = pre_q + 1'b1;
         end
      end
   end

   // An accept can never coincide with a swap: a swap needs pending full, which holds ready low.
   always_comb begin
      pend_valid_d    = pend_valid_q;
      pend_digits_d   = pend_digits_q;
      pend_dp_d       = pend_dp_q;
      shadow_digits_d = shadow_digits_q;
      shadow_dp_d     = shadow_dp_q;
      if (frame_wrap && pend_valid_q) begin
         shadow_digits_d = pend_digits_q;
         shadow_dp_d     = pend_dp_q;
         pend_valid_d    = 1'b0;
      end
      if (accept) begin
         pend_valid_d  = 1'b1;
         pend_digits_d = ld.digits_in;
         pend_dp_d     = ld.dp_in;
      end
   end

   // zero_from[i] is set when every nibble from the top down to i is zero.
   always_comb begin
      zero_from = '0;
      run_zero  = 1'b1;
      for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
         run_zero     = run_zero && (shadow_digits_q[4*i +: 4] == 4'h0);
         zero_from[i] = run_zero;
      end
   end

   assign lz_blank = blank_lz && (idx_q != '0) && zero_from[idx_q];
   assign phase    = pre_q / PRE_W'(PHASE_DIV);
   assign lit      = ena && (phase <= PRE_W'(bright));

   always_comb begin
      seg_d         = SEG_BLANK;
      dp_d          = 1'b0;
      dig_sel_d     = '0;
      frame_start_d = frame_wrap;
      if (lit) begin
         dig_sel_d = NUM_DIGITS'(1) << idx_q;
         if (!lz_blank) begin
            seg_d = dec_seg;
            dp_d  = shadow_dp_q[idx_q];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pre_q           <= '0;
         idx_q           <= '0;
         pend_valid_q    <= 1'b0;
         pend_digits_q   <= '0;
         pend_dp_q       <= '0;
         shadow_digits_q <= '0;
         shadow_dp_q     <= '0;
         seg_q           <= SEG_BLANK;
         dp_q            <= 1'b0;
         dig_sel_q       <= '0;
         frame_start_q   <= 1'b0;
      end else begin
         pre_q           <= pre_d;
         idx_q           <= idx_d;
         pend_valid_q    <= pend_valid_d;
         pend_digits_q   <= pend_digits_d;
         pend_dp_q       <= pend_dp_d;
         shadow_digits_q <= shadow_digits_d;
         shadow_dp_q     <= shadow_dp_d;
         seg_q           <= seg_d;
         dp_q            <= dp_d;
         dig_sel_q       <= dig_sel_d;
         frame_start_q   <= frame_start_d;
      end
   end

   assign seg_out     = seg_q;
   assign dp_out      = dp_q;
   assign dig_sel     = dig_sel_q;
   assign frame_start = frame_start_q;

endmodule
